// File: rtl/group_packer.sv
// Purpose : packs single DATA_WIDTH items into GROUP_SIZE-wide groups, zero-padding the last group of each iteration.
// Latency : the item that completes a group is accepted in cycle t; the group can leave in t+1, or in t+2 when the output register is held.
// Backpress: two group registers (pack + output); avail_out drops only when both are full, and valid_out fires only while avail_in=1.
//
// Ports:
//   clk, rst (async, active low)
//   configure / num_iters / num_items_per_iter : one-cycle run load; also aborts a run in progress
//   data_in / valid_in / avail_out             : item input, accepted when valid_in & avail_out
//   data_out / valid_out / avail_in            : group output, slot 0 in the low bits; transfer = valid_out
//   done                                       : pulses with the last transfer of the run (or one cycle after a zero-count configure)
// Build option GROUP_PACKER_STATS_EN adds the groups_sent / items_dropped counters and ports.
module group_packer #(
   parameter int GROUP_SIZE             = 8,
   parameter int DATA_WIDTH             = 8,
   parameter int LOG_MAX_ITERS          = 16,
   parameter int LOG_MAX_ITEMS_PER_ITER = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              configure,
   input  logic [LOG_MAX_ITERS-1:0]          num_iters,
   input  logic [LOG_MAX_ITEMS_PER_ITER-1:0] num_items_per_iter,
   input  logic [DATA_WIDTH-1:0]             data_in,
   input  logic                              valid_in,
   output logic                              avail_out,
   output logic [GROUP_SIZE*DATA_WIDTH-1:0]  data_out,
   output logic                              valid_out,
   input  logic                              avail_in,
   output logic                              done
`ifdef GROUP_PACKER_STATS_EN
   ,
   output logic [31:0]                       groups_sent,
   output logic [15:0]                       items_dropped
`endif
);

   localparam int GW = GROUP_SIZE * DATA_WIDTH;
   localparam int SW = $clog2(GROUP_SIZE);

   typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

   state_t                            state_q, state_d;
   logic [LOG_MAX_ITERS-1:0]          iters_left_q, iters_left_d;
   logic [LOG_MAX_ITEMS_PER_ITER-1:0] items_left_q, items_left_d;
   logic [LOG_MAX_ITEMS_PER_ITER-1:0] items_copy_q, items_copy_d;
   logic [SW-1:0]                     slot_idx_q, slot_idx_d;
   logic [GW-1:0]                     pack_q, pack_d;
   logic                              pack_full_q, pack_full_d;
   logic [GW-1:0]                     out_q, out_d;
   logic                              out_valid_q, out_valid_d;
   logic                              zero_cfg_q, zero_cfg_d;

   logic          cfg_ok;
   logic          accept;
   logic          last_item;
   logic          grp_done;
   logic          out_free;
   logic          final_xfer;
   logic [GW-1:0] grp_data;

   assign cfg_ok = (num_iters != '0) && (num_items_per_iter != '0);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         iters_left_q <= '0;
         items_left_q <= '0;
         items_copy_q <= '0;
         slot_idx_q   <= '0;
         pack_q       <= '0;
         pack_full_q  <= 1'b0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         zero_cfg_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         iters_left_q <= iters_left_d;
         items_left_q <= items_left_d;
         items_copy_q <= items_copy_d;
         slot_idx_q   <= slot_idx_d;
         pack_q       <= pack_d;
         pack_full_q  <= pack_full_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         zero_cfg_q   <= zero_cfg_d;
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      avail_out  = (state_q == PACK) && !configure && !pack_full_q;
      // A configure cycle discards the held group, so it must not be offered.
      valid_out  = out_valid_q && avail_in && !configure;
      // Last group of the run: nothing left behind it in the pack register.
      final_xfer = (state_q == FLUSH) && valid_out && !pack_full_q;
      done       = final_xfer || zero_cfg_q;
      data_out   = out_q;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      if (configure) begin
         state_d = cfg_ok ? PACK : IDLE;
      end else begin
         unique case (state_q)
            PACK:    if (accept && last_item && iters_left_q <= LOG_MAX_ITERS'(1)) state_d = FLUSH;
            FLUSH:   if (final_xfer) state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   // ---------------- datapath ----------------
   always_comb begin
      accept    = valid_in && avail_out;
      last_item = (items_left_q == LOG_MAX_ITEMS_PER_ITER'(1));
      grp_done  = accept && ((slot_idx_q == SW'(GROUP_SIZE - 1)) || last_item);
      // Output register can take a new group if empty or emptying this cycle.
      out_free  = !out_valid_q || valid_out;

      grp_data = pack_q;
      grp_data[int'(slot_idx_q)*DATA_WIDTH +: DATA_WIDTH] = data_in;
      if (grp_done) begin
         for (int i = 0; i < GROUP_SIZE; i++) begin
            if (i > int'(slot_idx_q)) grp_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
      end

      iters_left_d = iters_left_q;
      items_left_d = items_left_q;
      items_copy_d = items_copy_q;
      slot_idx_d   = slot_idx_q;
      pack_d       = pack_q;
      pack_full_d  = pack_full_q;
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      zero_cfg_d   = configure && !cfg_ok;

      if (configure) begin
         iters_left_d = num_iters;
         items_left_d = num_items_per_iter;
         items_copy_d = num_items_per_iter;
         slot_idx_d   = '0;
         pack_d       = '0;
         pack_full_d  = 1'b0;
         out_valid_d  = 1'b0;
      end else begin
         if (valid_out) out_valid_d = 1'b0;

         if (pack_full_q && out_free) begin
            out_d       = pack_q;
            out_valid_d = 1'b1;
            pack_full_d = 1'b0;
         end

         // accept implies pack register empty, so it never collides with the move above.
         if (accept) begin
            pack_d       = grp_data;
            items_left_d = items_left_q - 1'b1;
            slot_idx_d   = slot_idx_q + 1'b1;
            if (grp_done) begin
               slot_idx_d = '0;
               // Completed group skips the pack stage when the output slot is free.
               if (out_free) begin
                  out_d       = grp_data;
                  out_valid_d = 1'b1;
               end else begin
                  pack_full_d = 1'b1;
               end
            end
            if (last_item && iters_left_q > LOG_MAX_ITERS'(1)) begin
               iters_left_d = iters_left_q - 1'b1;
               items_left_d = items_copy_q;
            end
         end
      end
   end

`ifdef GROUP_PACKER_STATS_EN
   logic [31:0] groups_sent_q, groups_sent_d;
   logic [15:0] items_dropped_q, items_dropped_d;

   always_comb begin
      groups_sent_d   = groups_sent_q;
      items_dropped_d = items_dropped_q;
      if (configure) begin
         groups_sent_d   = '0;
         items_dropped_d = '0;
      end else begin
         if (valid_out) groups_sent_d = groups_sent_q + 32'd1;
         if (valid_in && !avail_out && (state_q != IDLE) && (items_dropped_q != 16'hFFFF))
            items_dropped_d = items_dropped_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         groups_sent_q   <= '0;
         items_dropped_q <= '0;
      end else begin
         groups_sent_q   <= groups_sent_d;
         items_dropped_q <= items_dropped_d;
      end
   end

   assign groups_sent   = groups_sent_q;
   assign items_dropped = items_dropped_q;
`endif

endmodule

// File: tb/tb_group_packer.sv
// Purpose : self-checking bench for group_packer (GROUP_SIZE=4, DATA_WIDTH=8) with a group scoreboard.
// Latency : expected groups are queued when a run is configured and popped on each valid_out.
// Backpress: the item driver holds each item until avail_out accepts it; avail_in is steered per test.
module tb_group_packer;

   localparam int GS = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          configure = 1'b0;
   logic [15:0]   num_iters = '0;
   logic [15:0]   num_items_per_iter = '0;
   logic [DW-1:0] data_in = '0;
   logic          valid_in = 1'b0;
   logic          avail_out;
   logic [GS*DW-1:0] data_out;
   logic          valid_out;
   logic          avail_in = 1'b1;
   logic          done;
`ifdef GROUP_PACKER_STATS_EN
   logic [31:0]   groups_sent;
   logic [15:0]   items_dropped;
`endif

   group_packer #(
      .GROUP_SIZE(GS), .DATA_WIDTH(DW), .LOG_MAX_ITERS(16), .LOG_MAX_ITEMS_PER_ITER(16)
   ) dut (
      .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
      .num_items_per_iter(num_items_per_iter), .data_in(data_in), .valid_in(valid_in),
      .avail_out(avail_out), .data_out(data_out), .valid_out(valid_out),
      .avail_in(avail_in), .done(done)
`ifdef GROUP_PACKER_STATS_EN
      , .groups_sent(groups_sent), .items_dropped(items_dropped)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int vo_cnt = 0;
   int done_cnt = 0;
   logic [31:0] exp_q[$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] item_val(input int k, input int items, input int start, input bit restart);
      int v;
      v = restart ? start + (k % items) : start + k;
      return v[7:0];
   endfunction

   // Reference grouping: fresh group per iteration, zero padding on the short tail.
   task automatic model_push(input int iters, input int items, input int start, input bit restart);
      logic [31:0] g;
      int slot;
      for (int it = 0; it < iters; it++) begin
         g = '0;
         slot = 0;
         for (int j = 0; j < items; j++) begin
            g[slot*8 +: 8] = item_val(it*items + j, items, start, restart);
            slot++;
            if (slot == GS || j == items - 1) begin
               exp_q.push_back(g);
               g = '0;
               slot = 0;
            end
         end
      end
   endtask

   // Monitor: sample outputs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst && valid_out) begin
         vo_cnt++;
         check_val("contract_avail_in", {63'd0, avail_in}, 64'd1);
         check_val("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
         if (exp_q.size() != 0) check_val("group_data", {32'd0, data_out}, {32'd0, exp_q.pop_front()});
      end
      if (rst && done) done_cnt++;
   end

   // Called and returning at posedge+1.
   task automatic do_config(input int iters, input int items);
      configure = 1'b1;
      num_iters = 16'(iters);
      num_items_per_iter = 16'(items);
      @(posedge clk); #1;
      configure = 1'b0;
   endtask

   task automatic send_items(input int items, input int start, input bit restart, input int from_idx, input int to_idx);
      for (int k = from_idx; k < to_idx; k++) begin
         bit acc;
         acc = 1'b0;
         data_in = item_val(k, items, start, restart);
         valid_in = 1'b1;
         for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = avail_out;
            @(posedge clk); #1;
         end
         if (!acc) begin
            check_val("accept_timeout", {63'd0, acc}, 64'd1);
            break;
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int d0;
      d0 = done_cnt;
      for (int c = 0; c < 300 && done_cnt == d0; c++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      check_val({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
      check_val({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int v0;
      int d0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_avail_out", {63'd0, avail_out}, 64'd0);
      check_val("rst_valid_out", {63'd0, valid_out}, 64'd0);
      check_val("rst_done", {63'd0, done}, 64'd0);
      check_val("rst_data_out", {32'd0, data_out}, 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // T1: one iteration, 8 items, full-rate output
      v0 = vo_cnt;
      model_push(1, 8, 1, 1'b0);
      do_config(1, 8);
      send_items(8, 1, 1'b0, 0, 8);
      wait_done("t1");
      check_val("t1_groups", 64'(vo_cnt - v0), 64'd2);

      // T2: two iterations of 6 items, padded tail groups
      v0 = vo_cnt;
      model_push(2, 6, 1, 1'b1);
      do_config(2, 6);
      send_items(6, 1, 1'b1, 0, 12);
      wait_done("t2");
      check_val("t2_groups", 64'(vo_cnt - v0), 64'd4);

      // T3: downstream blocked; both registers fill, extra items are dropped
      v0 = vo_cnt;
      avail_in = 1'b0;
      model_push(1, 12, 1, 1'b0);
      do_config(1, 12);
      send_items(12, 1, 1'b0, 0, 8);
      @(negedge clk);
      check_val("t3_full_avail_out", {63'd0, avail_out}, 64'd0);
      @(posedge clk); #1;
      data_in = 8'h09;
      valid_in = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_val("t3_stall_avail_out", {63'd0, avail_out}, 64'd0);
         @(posedge clk); #1;
      end
      valid_in = 1'b0;
      check_val("t3_held", 64'(vo_cnt - v0), 64'd0);
`ifdef GROUP_PACKER_STATS_EN
      check_val("t3_items_dropped", {48'd0, items_dropped}, 64'd3);
      check_val("t3_groups_sent0", {32'd0, groups_sent}, 64'd0);
`endif
      avail_in = 1'b1;
      send_items(12, 1, 1'b0, 8, 12);
      wait_done("t3");
      check_val("t3_groups", 64'(vo_cnt - v0), 64'd3);
`ifdef GROUP_PACKER_STATS_EN
      check_val("t3_groups_sent", {32'd0, groups_sent}, 64'd3);
`endif

      // T4: async reset mid-run, then a clean short run
      do_config(1, 8);
      send_items(8, 1, 1'b0, 0, 3);
      #2 rst = 1'b0;
      #1;
      check_val("t4_rst_avail_out", {63'd0, avail_out}, 64'd0);
      check_val("t4_rst_valid_out", {63'd0, valid_out}, 64'd0);
      check_val("t4_rst_data_out", {32'd0, data_out}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      v0 = vo_cnt;
      model_push(1, 4, 8'hA1, 1'b0);
      do_config(1, 4);
      send_items(4, 8'hA1, 1'b0, 0, 4);
      wait_done("t4");
      check_val("t4_groups", 64'(vo_cnt - v0), 64'd1);

      // T5: zero iteration count
      v0 = vo_cnt;
      d0 = done_cnt;
      configure = 1'b1;
      num_iters = 16'd0;
      num_items_per_iter = 16'd5;
      @(negedge clk);
      check_val("t5_done_early", {63'd0, done}, 64'd0);
      @(posedge clk); #1;
      configure = 1'b0;
      @(negedge clk);
      check_val("t5_done", {63'd0, done}, 64'd1);
      check_val("t5_avail_out", {63'd0, avail_out}, 64'd0);
      repeat (4) @(posedge clk);
      #1;
      check_val("t5_no_groups", 64'(vo_cnt - v0), 64'd0);
      check_val("t5_done_count", 64'(done_cnt - d0), 64'd1);
      check_val("t5_avail_out_late", {63'd0, avail_out}, 64'd0);

      // T6: configure during a run discards held groups
      avail_in = 1'b0;
      do_config(1, 8);
      send_items(8, 1, 1'b0, 0, 5);
      avail_in = 1'b1;
      configure = 1'b1;
      num_iters = 16'd1;
      num_items_per_iter = 16'd4;
      @(negedge clk);
      check_val("t6_abort_valid_out", {63'd0, valid_out}, 64'd0);
      @(posedge clk); #1;
      configure = 1'b0;
      @(negedge clk);
      check_val("t6_discard_valid_out", {63'd0, valid_out}, 64'd0);
      @(posedge clk); #1;
      v0 = vo_cnt;
      model_push(1, 4, 8'hB1, 1'b0);
      send_items(4, 8'hB1, 1'b0, 0, 4);
      wait_done("t6");
      check_val("t6_groups", 64'(vo_cnt - v0), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
